// File: rtl/instr_fetch_seq.sv
// -----------------------------------------------------------------------------
// instr_fetch_seq
//
// Byte-serial instruction fetch sequencer for a multicycle MIPS core that sits
// on an 8-bit memory. On an accepted fetch request it reads the four bytes at
// PC..PC+3 over a valid-handshaked byte bus. Each returned byte is presented to
// the instruction register with a one-hot IRWrite strobe, so the word assembles
// big-endian (first byte -> bits 31:24). Completion, misalignment and memory
// timeout are reported back to the control FSM, together with PC+4.
//
// Ports
//   clk_i        : core clock, all state on the rising edge
//   rst_n_i      : asynchronous active-low reset
//   start_i      : fetch request, sampled only while idle
//   abort_i      : cancel a fetch in progress
//   pc_i         : fetch address, sampled with start_i
//   mem_rd_o     : byte read request
//   mem_addr_o   : byte read address
//   mem_valid_i  : mem_rdata_i valid, completes the current read
//   mem_rdata_i  : read byte
//   IRWrite_o    : one-hot byte strobe to the instruction register (bit3 first)
//   instr8bit_o  : byte for the instruction register, coincident with IRWrite_o
//   fetch_en_o   : 1 = instruction register holds, 0 = assembling
//   busy_o       : sequence in progress
//   done_o       : one-cycle pulse, word complete
//   err_o        : one-cycle pulse, misaligned PC or memory timeout
//   pc_next_o    : pc_i + 4 latched at the accepted start (wraps)
//
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module instr_fetch_seq #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_valid_i,
  input  logic [7:0]        mem_rdata_i,
  output logic [3:0]        IRWrite_o,
  output logic [7:0]        instr8bit_o,
  output logic              fetch_en_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] pc_next_o
);

  // Timer counts 0..TIMEOUT-1; hitting TIMEOUT-1 on another empty cycle aborts.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LAST = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        irwrite_q, irwrite_d;
  logic [7:0]        instr8_q, instr8_d;
  logic              fetch_en_q, fetch_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] pc_next_q, pc_next_d;

  // Next-state and next-output logic for the fetch sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    irwrite_d  = 4'b0000;
    instr8_d   = instr8_q;
    fetch_en_d = 1'b1;
    done_d     = 1'b0;
    err_d      = 1'b0;
    pc_next_d  = pc_next_q;

    case (state_q)
      ST_IDLE: begin
        // abort_i is deliberately not looked at here.
        if (start_i) begin
          if (pc_i[1:0] == 2'b00) begin
            state_d    = ST_READ;
            cnt_d      = 2'd0;
            timer_d    = '0;
            mem_rd_d   = 1'b1;
            mem_addr_d = pc_i;
            fetch_en_d = 1'b0;
            pc_next_d  = pc_i + ADDR_W'(4);
          end else begin
            // Misaligned: flag and stay idle without touching memory.
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_READ: begin
        if (abort_i) begin
          // Abort wins over a same-cycle byte or timeout; outputs fall to idle.
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (mem_valid_i) begin
          irwrite_d  = 4'b1000 >> cnt_q;
          instr8_d   = mem_rdata_i;
          timer_d    = '0;
          fetch_en_d = 1'b0;
          if (cnt_q == 2'd3) begin
            state_d = ST_LAST;
            done_d  = 1'b1;
          end else begin
            // Next byte request issued back-to-back, no bubble.
            cnt_d      = cnt_q + 2'd1;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            mem_rd_d   = 1'b1;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          timer_d = '0;
          err_d   = 1'b1;
        end else begin
          timer_d    = timer_q + TW'(1);
          mem_rd_d   = 1'b1;
          fetch_en_d = 1'b0;
        end
      end

      ST_LAST: begin
        // The last byte strobe and done are already on the outputs.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered-output flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      timer_q    <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      irwrite_q  <= 4'b0000;
      instr8_q   <= 8'h00;
      fetch_en_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pc_next_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      irwrite_q  <= irwrite_d;
      instr8_q   <= instr8_d;
      fetch_en_q <= fetch_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pc_next_q  <= pc_next_d;
    end
  end

  assign mem_rd_o    = mem_rd_q;
  assign mem_addr_o  = mem_addr_q;
  assign IRWrite_o   = irwrite_q;
  assign instr8bit_o = instr8_q;
  assign fetch_en_o  = fetch_en_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign pc_next_o   = pc_next_q;

endmodule
